// File: rtl/spm_host_ctrl_if.sv
// Request/response bus for the serial-parallel multiplier host sequencer.
// master = initiator issuing operand pairs, slave = spm_host_ctrl.
interface spm_host_ctrl_if #(
  parameter int WIDTH = 32
);
  logic               req_valid;
  logic               req_ready;
  logic [WIDTH-1:0]   req_a;
  logic [WIDTH-1:0]   req_b;
  logic               resp_valid;
  logic               resp_ready;
  logic [2*WIDTH-1:0] resp_p;

  modport master (
    output req_valid, req_a, req_b, resp_ready,
    input  req_ready, resp_valid, resp_p
  );

  modport slave (
    input  req_valid, req_a, req_b, resp_ready,
    output req_ready, resp_valid, resp_p
  );
endinterface

// File: rtl/spm_host_ctrl.sv
// spm_host_ctrl: initiator-side sequencer for a serial-parallel multiplier.
// Latches an operand pair, presents the multiplicand in parallel, streams the
// multiplier LSB-first, deserialises the 2*WIDTH-bit product and returns it.
// Optional watchdog on the RUN phase: define SPM_HOST_TIMEOUT_EN to add the
// err port and a TIMEOUT_CYCLES limit on waiting for spm_done.
module spm_host_ctrl #(
  parameter int WIDTH          = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  spm_host_ctrl_if.slave   host,
  output logic             spm_start,
  output logic             spm_proddone,
  input  logic             spm_ld,
  input  logic             spm_shift,
  input  logic             spm_done,
  output logic [WIDTH-1:0] spm_x,
  output logic             spm_ybit,
  input  logic             spm_pbit
`ifdef SPM_HOST_TIMEOUT_EN
  ,
  output logic             err
`endif
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(PW) + 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(PW);

  // Reject nonsensical configurations at elaboration.
  if (WIDTH < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("spm_host_ctrl: WIDTH and TIMEOUT_CYCLES must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] x_q;
  logic [WIDTH-1:0] y_q;
  logic [PW-1:0]    prod_q;
  logic [CW-1:0]    cnt_q;
  logic             resp_valid_q;
  logic             accept;
  logic             cnt_full;

`ifdef SPM_HOST_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam logic [TW-1:0] WD_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] wd_q;
`endif

  // Only take a new request once the multiplier itself is back in its
  // load state; this covers the cycle it spends leaving done.
  assign host.req_ready  = (state == IDLE) && spm_ld;
  assign accept          = host.req_valid && host.req_ready;
  assign cnt_full        = (cnt_q == CNT_MAX);

  assign spm_proddone    = cnt_full;
  assign spm_x           = x_q;
  assign spm_ybit        = y_q[0];
  assign host.resp_valid = resp_valid_q;
  assign host.resp_p     = prod_q;

  // Sequencer FSM with all control and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      spm_start    <= 1'b0;
      cnt_q        <= '0;
      x_q          <= '0;
      y_q          <= '0;
      prod_q       <= '0;
      resp_valid_q <= 1'b0;
`ifdef SPM_HOST_TIMEOUT_EN
      wd_q         <= '0;
      err          <= 1'b0;
`endif
    end else begin
`ifdef SPM_HOST_TIMEOUT_EN
      err <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (accept) begin
            x_q       <= host.req_a;
            y_q       <= host.req_b;
            cnt_q     <= '0;
            prod_q    <= '0;
            spm_start <= 1'b1;
`ifdef SPM_HOST_TIMEOUT_EN
            wd_q      <= '0;
`endif
            state     <= RUN;
          end
        end

        RUN: begin
          // Shifts past the last product bit are ignored so a misbehaving
          // multiplier cannot corrupt a completed product.
          if (spm_shift && !cnt_full) begin
            prod_q <= {spm_pbit, prod_q[PW-1:1]};
            y_q    <= {1'b0, y_q[WIDTH-1:1]};
            cnt_q  <= cnt_q + 1'b1;
          end
          if (spm_done) begin
            resp_valid_q <= 1'b1;
            state        <= RESP;
          end
`ifdef SPM_HOST_TIMEOUT_EN
          else if (wd_q == WD_LAST) begin
            err       <= 1'b1;
            spm_start <= 1'b0;
            cnt_q     <= '0;
            state     <= IDLE;
          end else begin
            wd_q <= wd_q + 1'b1;
          end
`endif
        end

        RESP: begin
          // spm_start stays high here to park the multiplier in done.
          if (host.resp_ready) begin
            resp_valid_q <= 1'b0;
            spm_start    <= 1'b0;
            cnt_q        <= '0;
            state        <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spm_host_ctrl.sv
// Testbench for spm_host_ctrl with WIDTH=8 and a behavioural multiplier.
// Product bits are generated from the observed multiplier bit stream, so a
// broken ybit or pbit path shows up as a wrong product.
module tb_spm_host_ctrl;
  localparam int W  = 8;
  localparam int TO = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic spm_start, spm_proddone, spm_ld, spm_shift, spm_done, spm_ybit, spm_pbit;
  logic [W-1:0] spm_x;
`ifdef SPM_HOST_TIMEOUT_EN
  logic err;
`endif

  spm_host_ctrl_if #(.WIDTH(W)) bus ();

  spm_host_ctrl #(.WIDTH(W), .TIMEOUT_CYCLES(TO)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .host         (bus),
    .spm_start    (spm_start),
    .spm_proddone (spm_proddone),
    .spm_ld       (spm_ld),
    .spm_shift    (spm_shift),
    .spm_done     (spm_done),
    .spm_x        (spm_x),
    .spm_ybit     (spm_ybit),
    .spm_pbit     (spm_pbit)
`ifdef SPM_HOST_TIMEOUT_EN
    ,
    .err          (err)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors = 0;
  int fails   = 0;
  bit hang    = 1'b0;

  // ---------------- behavioural multiplier ----------------
  typedef enum logic [1:0] {M_IDLE, M_LOAD, M_SHIFT, M_DONE} m_t;
  m_t          m_st;
  logic [15:0] yacc;
  logic [4:0]  sidx;
  logic [31:0] yv, pr;

  assign spm_ld    = (m_st == M_IDLE);
  assign spm_done  = (m_st == M_DONE);
  assign spm_shift = (m_st == M_SHIFT) && !spm_proddone;

  // Product bit i of x*y depends only on y bits 0..i.
  always_comb begin
    yv = {16'b0, yacc} | (32'(spm_ybit) << sidx);
    pr = 32'(spm_x) * yv;
    spm_pbit = spm_shift ? pr[sidx] : 1'b0;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st <= M_IDLE;
      yacc <= '0;
      sidx <= '0;
    end else begin
      case (m_st)
        M_IDLE:  if (spm_start) m_st <= M_LOAD;
        M_LOAD: begin
          yacc <= '0;
          sidx <= '0;
          m_st <= spm_start ? M_SHIFT : M_IDLE;
        end
        M_SHIFT: begin
          if (!spm_start) m_st <= M_IDLE;
          else if (spm_shift) begin
            if (sidx < 5'd16) yacc[sidx[3:0]] <= spm_ybit;
            sidx <= sidx + 1'b1;
          end else if (spm_proddone && !hang) m_st <= M_DONE;
        end
        default: if (!spm_start) m_st <= M_IDLE;
      endcase
    end
  end

  // ---------------- shift monitor ----------------
  bit ybq[$];
  int nshift = 0;
  int last_shift = -1;
  int pd_rise = -1;
  bit pd_prev = 1'b0;
  always @(negedge clk) begin
    if (spm_shift) begin
      ybq.push_back(spm_ybit);
      nshift = nshift + 1;
      last_shift = cyc;
    end
    if (spm_proddone && !pd_prev) pd_rise = cyc;
    pd_prev = spm_proddone;
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, output int e);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_a = a;
    bus.req_b = b;
    e = -1;
    for (int i = 0; i < 40; i++) begin
      if (bus.req_ready) begin
        @(posedge clk);
        #1;
        e = cyc;
        break;
      end
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    ybq.delete();
    nshift = 0;
    last_shift = -1;
    pd_rise = -1;
    vectors++;
    if (e < 0) begin
      fails++;
      $display("FAIL accept: req_ready never seen for %0d x %0d", a, b);
    end
  endtask

  task automatic recv(input logic [2*W-1:0] exp, input int e, input int dly, output int t);
    logic [2*W-1:0] held;
    t = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.resp_valid) begin
        t = cyc;
        break;
      end
    end
    vectors++;
    if (t < 0) begin
      fails++;
      $display("FAIL resp_timeout: no resp_valid, expected product %h", exp);
      return;
    end
    if (t != e + 20) begin
      fails++;
      $display("FAIL latency: got %0d cycles, want 20", t - e);
    end
    vectors++;
    if (bus.resp_p !== exp) begin
      fails++;
      $display("FAIL product: got %h want %h", bus.resp_p, exp);
    end
    held = bus.resp_p;
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      vectors++;
      if (bus.resp_valid !== 1'b1 || bus.resp_p !== held || spm_start !== 1'b1) begin
        fails++;
        $display("FAIL backpressure_hold: valid=%b p=%h start=%b want 1 %h 1",
                 bus.resp_valid, bus.resp_p, spm_start, held);
      end
    end
    bus.resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.resp_ready = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1;
    vectors++;
    if (spm_start !== 1'b0 || bus.resp_valid !== 1'b0 || spm_x !== '0 ||
        spm_ybit !== 1'b0 || spm_proddone !== 1'b0 || bus.resp_p !== '0) begin
      fails++;
      $display("FAIL reset_vals: start=%b rv=%b x=%h ybit=%b pd=%b p=%h want all 0",
               spm_start, bus.resp_valid, spm_x, spm_ybit, spm_proddone, bus.resp_p);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (bus.req_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready: req_ready=%b want 1", bus.req_ready);
    end
  endtask

  task automatic test_basic();
    int e, t;
    send(8'd13, 8'd11, e);
    recv(16'h008F, e, 0, t);
    vectors++;
    if (ybq.size() != 16) begin
      fails++;
      $display("FAIL ybit_count: got %0d want 16", ybq.size());
    end else begin
      for (int i = 0; i < 16; i++) begin
        int want = (i < 8) ? ((11 >> i) & 1) : 0;
        vectors++;
        if (int'(ybq[i]) != want) begin
          fails++;
          $display("FAIL ybit[%0d]: got %0d want %0d", i, ybq[i], want);
        end
      end
    end
  endtask

  task automatic test_max();
    int e, t;
    send(8'hFF, 8'hFF, e);
    recv(16'hFE01, e, 0, t);
    vectors++;
    if (nshift != 16) begin
      fails++;
      $display("FAIL shift_count: got %0d want 16", nshift);
    end
    vectors++;
    if (last_shift != e + 17 || pd_rise != last_shift + 1) begin
      fails++;
      $display("FAIL proddone_timing: last_shift=%0d pd_rise=%0d want %0d %0d",
               last_shift - e, pd_rise - e, 17, 18);
    end
  endtask

  task automatic test_back_to_back();
    int e, t;
    send(8'h21, 8'h06, e);
    recv(16'h00C6, e, 5, t);
    // response accepted by recv; next request is presented right away
    @(negedge clk);
    vectors++;
    if (bus.req_ready !== 1'b0 || spm_start !== 1'b0 || bus.resp_valid !== 1'b0) begin
      fails++;
      $display("FAIL gap_cycle: ready=%b start=%b rv=%b want 0 0 0",
               bus.req_ready, spm_start, bus.resp_valid);
    end
    bus.req_valid = 1'b1;
    bus.req_a = 8'd3;
    bus.req_b = 8'd4;
    @(negedge clk);
    vectors++;
    if (bus.req_ready !== 1'b1) begin
      fails++;
      $display("FAIL ready_return: req_ready=%b want 1", bus.req_ready);
    end
    @(posedge clk);
    #1;
    e = cyc;
    bus.req_valid = 1'b0;
    recv(16'h000C, e, 0, t);
  endtask

  task automatic test_zero_illegal();
    int e, t;
    send(8'h00, 8'hA5, e);
    repeat (4) @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_a = 8'h77;
    bus.req_b = 8'h33;
    for (int i = 0; i < 6; i++) begin
      vectors++;
      if (bus.req_ready !== 1'b0 || spm_x !== 8'h00) begin
        fails++;
        $display("FAIL illegal_req: ready=%b x=%h want 0 00", bus.req_ready, spm_x);
      end
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    recv(16'h0000, e, 0, t);
  endtask

  task automatic test_reset_mid();
    int e, t;
    send(8'h5A, 8'h3C, e);
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    vectors++;
    if (spm_start !== 1'b0 || bus.resp_valid !== 1'b0 || spm_proddone !== 1'b0 ||
        dut.cnt_q !== '0 || spm_x !== '0) begin
      fails++;
      $display("FAIL reset_mid: start=%b rv=%b pd=%b cnt=%0d x=%h want 0 0 0 0 00",
               spm_start, bus.resp_valid, spm_proddone, dut.cnt_q, spm_x);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send(8'd7, 8'd9, e);
    recv(16'h003F, e, 0, t);
  endtask

  task automatic test_random();
    int e, t;
    for (int n = 0; n < 8; n++) begin
      logic [W-1:0] a, b;
      a = W'($urandom);
      b = W'($urandom);
      send(a, b, e);
      recv(16'(a) * 16'(b), e, int'($urandom_range(0, 3)), t);
    end
  endtask

`ifdef SPM_HOST_TIMEOUT_EN
  task automatic test_timeout();
    int e, t, r;
    hang = 1'b1;
    send(8'd5, 8'd6, e);
    t = -1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk);
      if (err === 1'b1) begin
        t = cyc;
        break;
      end
    end
    vectors++;
    if (t != e + TO) begin
      fails++;
      $display("FAIL err_timing: got %0d want %0d", t - e, TO);
    end
    vectors++;
    if (spm_start !== 1'b0 || bus.resp_valid !== 1'b0) begin
      fails++;
      $display("FAIL timeout_abort: start=%b rv=%b want 0 0", spm_start, bus.resp_valid);
    end
    @(negedge clk);
    vectors++;
    if (err !== 1'b0) begin
      fails++;
      $display("FAIL err_pulse: err=%b want 0", err);
    end
    r = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.req_ready === 1'b1) begin
        r = 1;
        break;
      end
      @(negedge clk);
    end
    vectors++;
    if (r != 1) begin
      fails++;
      $display("FAIL timeout_ready: req_ready=%b want 1", bus.req_ready);
    end
    hang = 1'b0;
    send(8'd2, 8'd3, e);
    recv(16'h0006, e, 0, t);
  endtask
`endif

  initial begin
    bus.req_valid  = 1'b0;
    bus.req_a      = '0;
    bus.req_b      = '0;
    bus.resp_ready = 1'b0;
    test_reset();
    test_basic();
    test_max();
    test_back_to_back();
    test_zero_illegal();
    test_reset_mid();
    test_random();
`ifdef SPM_HOST_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
endmodule
